// File: rtl/pipe_bpred.sv
// Direct-mapped branch target buffer with per-entry saturating counters,
// an init/flush walker that clears the table, and saturating branch/mispredict statistics.
module pipe_bpred #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INDEX_W = 4,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flush,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic              upd_is_branch,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
   output logic              ready,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  mis_cnt
);

   localparam int unsigned DEPTH = 1 << INDEX_W;
   localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              r_state, w_state_nxt;
   logic [INDEX_W-1:0]  r_ptr, w_ptr_nxt;

   logic                r_valid [DEPTH];
   logic [TAG_W-1:0]    r_tag   [DEPTH];
   logic [ADDR_W-1:0]   r_tgt   [DEPTH];
   logic [CTR_W-1:0]    r_ctr   [DEPTH];

   logic [CNT_W-1:0]    r_br_cnt, r_mis_cnt;

   logic [INDEX_W-1:0]  w_lidx, w_uidx;
   logic [TAG_W-1:0]    w_ltag, w_utag;
   logic                w_uhit, w_upd_en;
   logic                w_unused;

   assign w_lidx   = if_pc[INDEX_W+1:2];
   assign w_ltag   = if_pc[ADDR_W-1:INDEX_W+2];
   assign w_uidx   = upd_pc[INDEX_W+1:2];
   assign w_utag   = upd_pc[ADDR_W-1:INDEX_W+2];
   assign w_unused = ^{if_pc[1:0], upd_pc[1:0]};

   assign ready    = (r_state == S_RUN);
   assign w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
   assign w_upd_en = ready && upd_valid && !clr;

   // Lookup reads only registered state, so a same-cycle update is seen next cycle.
   assign pred_hit    = ready && r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
   assign pred_taken  = pred_hit && r_ctr[w_lidx][CTR_W-1];
   assign pred_target = pred_taken ? r_tgt[w_lidx] : if_pc + ADDR_W'(4);

   assign mispredict = upd_valid && upd_is_branch &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_INIT;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         S_INIT: begin
            if (flush) begin
               w_ptr_nxt = '0;
            end else begin
               w_ptr_nxt = r_ptr + INDEX_W'(1);
               if (r_ptr == '1) w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (flush) begin
               w_state_nxt = S_INIT;
               w_ptr_nxt   = '0;
            end
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   // Table contents need no reset: the walker clears every entry before ready rises.
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) begin
         r_valid[r_ptr] <= 1'b0;
         r_ctr[r_ptr]   <= '0;
      end else if (w_upd_en) begin
         if (upd_is_branch) begin
            if (w_uhit) begin
               if (upd_taken) begin
                  if (r_ctr[w_uidx] != '1) r_ctr[w_uidx] <= r_ctr[w_uidx] + CTR_W'(1);
                  r_tgt[w_uidx] <= upd_target;
               end else if (r_ctr[w_uidx] != '0) begin
                  r_ctr[w_uidx] <= r_ctr[w_uidx] - CTR_W'(1);
               end
            end else if (upd_taken) begin
               r_valid[w_uidx] <= 1'b1;
               r_tag[w_uidx]   <= w_utag;
               r_tgt[w_uidx]   <= upd_target;
               r_ctr[w_uidx]   <= CTR_WEAK;
            end
         end else if (w_uhit) begin
            r_valid[w_uidx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_br_cnt  <= '0;
         r_mis_cnt <= '0;
      end else if (ready && upd_valid && upd_is_branch) begin
         if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_W'(1);
         if (mispredict && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
   end

   assign br_cnt  = r_br_cnt;
   assign mis_cnt = r_mis_cnt;

endmodule

// File: tb/tb_pipe_bpred.sv
// Bench for pipe_bpred: directed plan steps followed by random traffic, checked
// every cycle against a table-of-entries reference model (default and CNT_W=4 instances).
module tb_pipe_bpred;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, flush, upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
   logic [31:0] if_pc, upd_pc, upd_target, upd_pred_target;

   logic        pred_hit, pred_taken, mispredict, ready;
   logic [31:0] pred_target;
   logic [15:0] br_cnt, mis_cnt;

   logic        pred_hit4, pred_taken4, mispredict4, ready4;
   logic [31:0] pred_target4;
   logic [3:0]  br_cnt4, mis_cnt4;

   pipe_bpred dut (
      .clk(clk), .clr(clr), .flush(flush), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .ready(ready), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   pipe_bpred #(.CNT_W(4)) dut4 (
      .clk(clk), .clr(clr), .flush(flush), .if_pc(if_pc),
      .pred_hit(pred_hit4), .pred_taken(pred_taken4), .pred_target(pred_target4),
      .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict4), .ready(ready4), .br_cnt(br_cnt4), .mis_cnt(mis_cnt4)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: 16 entries, counters kept as plain integers 0..3.
   bit          m_known = 1'b0;
   bit          m_ready;
   int          m_init;
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   int          m_br, m_mis, m_br4, m_mis4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit model_mp();
      if (!upd_valid || !upd_is_branch) return 1'b0;
      if (upd_pred_taken != upd_taken) return 1'b1;
      if (upd_taken && upd_target != upd_pred_target) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int sat_inc(input int v, input int top);
      return (v >= top) ? top : v + 1;
   endfunction

   task automatic model_edge();
      int idx;
      bit hit;
      if (clr) begin
         m_known = 1'b1;
         m_ready = 1'b0;
         m_init  = 16;
         m_br = 0; m_mis = 0; m_br4 = 0; m_mis4 = 0;
      end else if (!m_ready) begin
         if (flush) m_init = 16;
         else begin
            m_init--;
            if (m_init == 0) begin
               m_ready = 1'b1;
               for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end
         end
      end else begin
         if (upd_valid) begin
            idx = int'((upd_pc >> 2) % 16);
            hit = m_valid[idx] && (m_tag[idx] == (upd_pc >> 6));
            if (upd_is_branch) begin
               m_br  = sat_inc(m_br, 65535);
               m_br4 = sat_inc(m_br4, 15);
               if (model_mp()) begin
                  m_mis  = sat_inc(m_mis, 65535);
                  m_mis4 = sat_inc(m_mis4, 15);
               end
               if (hit) begin
                  if (upd_taken) begin
                     if (m_ctr[idx] < 3) m_ctr[idx]++;
                     m_tgt[idx] = upd_target;
                  end else if (m_ctr[idx] > 0) m_ctr[idx]--;
               end else if (upd_taken) begin
                  m_valid[idx] = 1'b1;
                  m_tag[idx]   = upd_pc >> 6;
                  m_tgt[idx]   = upd_target;
                  m_ctr[idx]   = 2;
               end
            end else if (hit) m_valid[idx] = 1'b0;
         end
         if (flush) begin
            m_ready = 1'b0;
            m_init  = 16;
         end
      end
   endtask

   task automatic cyc();
      int          idx;
      bit          hit, tk;
      logic [31:0] tg;
      @(negedge clk);
      if (m_known) begin
         idx = int'((if_pc >> 2) % 16);
         hit = m_ready && m_valid[idx] && (m_tag[idx] == (if_pc >> 6));
         tk  = hit && (m_ctr[idx] >= 2);
         tg  = tk ? m_tgt[idx] : if_pc + 32'd4;
         chk("ready",       {31'd0, ready},       {31'd0, m_ready});
         chk("pred_hit",    {31'd0, pred_hit},    {31'd0, hit});
         chk("pred_taken",  {31'd0, pred_taken},  {31'd0, tk});
         chk("pred_target", pred_target,          tg);
         chk("mispredict",  {31'd0, mispredict},  {31'd0, model_mp()});
         chk("br_cnt",      {16'd0, br_cnt},      m_br);
         chk("mis_cnt",     {16'd0, mis_cnt},     m_mis);
         chk("br_cnt4",     {28'd0, br_cnt4},     m_br4);
         chk("mis_cnt4",    {28'd0, mis_cnt4},    m_mis4);
         chk("mispredict4", {31'd0, mispredict4}, {31'd0, model_mp()});
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
      upd_valid = 1'b1; upd_is_branch = br; upd_pc = pc; upd_taken = tk;
      upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
      cyc();
      upd_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick_pc();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0040;
         1: return 32'h0000_0080;
         2: return 32'h0000_0044;
         3: return 32'h0000_1040;
         4: return 32'hFFFF_FFFC;
         5: return 32'h0000_03C0;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] pick_tgt();
      case ($urandom_range(0, 3))
         0: return 32'h0000_0100;
         1: return 32'h0000_0104;
         2: return 32'h0000_0200;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int cnt;
      clr = 1'b1; flush = 1'b0; if_pc = 32'h40;
      upd_valid = 1'b0; upd_is_branch = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;

      // 1: clr, then exactly 16 cycles of INIT
      cyc();
      clr = 1'b0;
      cnt = 0;
      while (!ready && cnt < 40) begin
         cyc();
         cnt++;
      end
      chk("init_len", cnt, 16);
      if_pc = 32'h40;
      cyc();
      if_pc = 32'hFFFF_FFFC;
      cyc();

      // 2: allocate 0x40 weakly taken
      if_pc = 32'h40;
      upd(32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
      cyc();

      // 3: saturate up, walk down, saturate at 0
      repeat (3) upd(32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100);
      repeat (2) upd(32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 32'h100);
      cyc();
      repeat (2) upd(32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 32'h44);
      cyc();

      // 4: alias replacement at index 0, with same-cycle lookup of the new PC
      upd(32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
      if_pc = 32'h80;
      upd(32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84);
      cyc();
      if_pc = 32'h40;
      cyc();
      upd(32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      // 5: flush with 0x40 allocated; updates during INIT; re-flush at INIT cycle 8
      upd(32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
      flush = 1'b1; cyc(); flush = 1'b0;
      repeat (7) upd(32'h40, 1'b1, 1'b1, 32'h300, 1'b0, 32'h44);
      flush = 1'b1; cyc(); flush = 1'b0;
      cnt = 0;
      while (!ready && cnt < 40) begin
         cyc();
         cnt++;
      end
      chk("reinit_len", cnt, 16);
      cyc();

      // 6: counter saturation in the CNT_W=4 instance, then target-only mispredict
      repeat (20) upd(pick_pc(), 1'b1, 1'b1, pick_tgt(), 1'b0, 32'h0);
      chk("br_cnt4_sat", {28'd0, br_cnt4}, 32'd15);
      upd(32'h40, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100);

      // Random traffic with occasional flush and clr
      repeat (800) begin
         if_pc          = pick_pc();
         upd_valid      = ($urandom_range(0, 3) != 0);
         upd_is_branch  = ($urandom_range(0, 4) != 0);
         upd_pc         = pick_pc();
         upd_taken      = $urandom_range(0, 1) == 1;
         upd_target     = pick_tgt();
         upd_pred_taken = $urandom_range(0, 1) == 1;
         upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target : pick_tgt();
         flush          = ($urandom_range(0, 59) == 0);
         clr            = ($urandom_range(0, 299) == 0);
         cyc();
      end
      clr = 1'b0; flush = 1'b0; upd_valid = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
